// File: rtl/cache_axi_read_arbiter.sv
// Arbitrates the instruction and data cache read-burst requests onto one
// AXI read channel. Only one burst is in flight at a time. An idle owner
// register and a last_owner register give round-robin priority when both
// caches request in the same cycle. Read data is shared by both caches.
module cache_axi_read_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  // i-cache side
  input  logic [ADDR_W-1:0] inst_araddr,
  input  logic [3:0]        inst_arlen,
  input  logic              inst_arvalid,
  output logic              inst_arready,
  output logic              inst_rvalid,
  output logic              inst_rlast,
  input  logic              inst_rready,

  // d-cache side
  input  logic [ADDR_W-1:0] data_araddr,
  input  logic [3:0]        data_arlen,
  input  logic              data_arvalid,
  output logic              data_arready,
  output logic              data_rvalid,
  output logic              data_rlast,
  input  logic              data_rready,

  // shared read data
  output logic [31:0]       rdata_out,

  // AXI read master
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;            // 0 = inst, 1 = data
  logic   last_owner_q, last_owner_d;  // owner of the most recently completed burst

  // Request and beat-accept of whichever cache currently owns the channel.
  logic owner_arvalid;
  logic owner_rready;

  assign owner_arvalid = owner_q ? data_arvalid : inst_arvalid;
  assign owner_rready  = owner_q ? data_rready  : inst_rready;

  // Next-state logic: grant in IDLE, address handshake in ADDR, burst end in DATA.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (inst_arvalid && data_arvalid) begin
          // Both waiting: the cache that did not win last time goes first.
          owner_d = ~last_owner_q;
          state_d = ADDR;
        end else if (data_arvalid) begin
          owner_d = 1'b1;
          state_d = ADDR;
        end else if (inst_arvalid) begin
          owner_d = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!owner_arvalid) begin
          // Requester withdrew before the address was taken; nothing issued.
          state_d = IDLE;
        end else if (arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        // The burst ends on the beat flagged last, whatever its length.
        if (rvalid && owner_rready && rlast) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset returns to IDLE with the i-cache as nominal owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Output steering decoded from the registered state, so everything drops
  // the instant reset asserts; handshake signals pass straight through.
  always_comb begin
    inst_arready = 1'b0;
    data_arready = 1'b0;
    inst_rvalid  = 1'b0;
    inst_rlast   = 1'b0;
    data_rvalid  = 1'b0;
    data_rlast   = 1'b0;
    arvalid      = 1'b0;
    araddr       = '0;
    arlen        = 4'd0;
    arid         = 4'd0;
    rready       = 1'b0;
    case (state_q)
      ADDR: begin
        arvalid = owner_arvalid;
        araddr  = owner_q ? data_araddr : inst_araddr;
        arlen   = owner_q ? data_arlen  : inst_arlen;
        arid    = {3'b000, owner_q};
        if (owner_q) begin
          data_arready = arready;
        end else begin
          inst_arready = arready;
        end
      end
      DATA: begin
        rready = owner_rready;
        if (owner_q) begin
          data_rvalid = rvalid;
          data_rlast  = rlast;
        end else begin
          inst_rvalid = rvalid;
          inst_rlast  = rlast;
        end
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; the per-cache rvalid qualifies it.
  assign rdata_out = rdata;

endmodule

// File: tb/tb_cache_axi_read_arbiter.sv
// Directed bench for cache_axi_read_arbiter: a burst-level model of the
// arbiter is compared with every DUT output on each falling edge, and
// literal checks pin grant order, latency and reset behaviour.
module tb_cache_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_araddr, data_araddr, araddr, rdata, rdata_out;
  logic [3:0]  inst_arlen, data_arlen, arlen, arid;
  logic        inst_arvalid, inst_arready, inst_rvalid, inst_rlast, inst_rready;
  logic        data_arvalid, data_arready, data_rvalid, data_rlast, data_rready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int tests = 0;
  int fails = 0;
  int inst_beats = 0;
  int data_beats = 0;
  bit chk_en = 1'b0;

  cache_axi_read_arbiter #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_araddr  (inst_araddr),
    .inst_arlen   (inst_arlen),
    .inst_arvalid (inst_arvalid),
    .inst_arready (inst_arready),
    .inst_rvalid  (inst_rvalid),
    .inst_rlast   (inst_rlast),
    .inst_rready  (inst_rready),
    .data_araddr  (data_araddr),
    .data_arlen   (data_arlen),
    .data_arvalid (data_arvalid),
    .data_arready (data_arready),
    .data_rvalid  (data_rvalid),
    .data_rlast   (data_rlast),
    .data_rready  (data_rready),
    .rdata_out    (rdata_out),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  always #5 clk = ~clk;

  // ---------------- burst-level model ----------------
  // m_busy: a burst is granted; m_addr_done: its address has been taken.
  bit m_busy = 1'b0, m_who = 1'b0, m_addr_done = 1'b0, m_last = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_who <= 1'b0; m_addr_done <= 1'b0; m_last <= 1'b0;
    end else if (!m_busy) begin
      if (inst_arvalid || data_arvalid) begin
        m_busy      <= 1'b1;
        m_addr_done <= 1'b0;
        m_who       <= (inst_arvalid && data_arvalid) ? !m_last : data_arvalid;
      end
    end else if (!m_addr_done) begin
      if (!(m_who ? data_arvalid : inst_arvalid)) m_busy <= 1'b0;
      else if (arready) m_addr_done <= 1'b1;
    end else if (rvalid && rlast && (m_who ? data_rready : inst_rready)) begin
      m_busy <= 1'b0;
      m_last <= m_who;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [79:0] exp_v, act_v;
  logic        addr_ph, data_ph;

  always @(negedge clk) begin
    if (chk_en) begin
      addr_ph = !rst && m_busy && !m_addr_done;
      data_ph = !rst && m_busy && m_addr_done;
      exp_v = '0;
      exp_v[31:0] = rdata;
      if (addr_ph) begin
        exp_v[79]    = !m_who && arready;
        exp_v[76]    = m_who && arready;
        exp_v[73]    = m_who ? data_arvalid : inst_arvalid;
        exp_v[71:68] = {3'b000, m_who};
        exp_v[67:64] = m_who ? data_arlen : inst_arlen;
        exp_v[63:32] = m_who ? data_araddr : inst_araddr;
      end
      if (data_ph) begin
        exp_v[78] = !m_who && rvalid;
        exp_v[77] = !m_who && rlast;
        exp_v[75] = m_who && rvalid;
        exp_v[74] = m_who && rlast;
        exp_v[72] = m_who ? data_rready : inst_rready;
      end
      act_v = {inst_arready, inst_rvalid, inst_rlast, data_arready, data_rvalid,
               data_rlast, arvalid, rready, arid, arlen, araddr, rdata_out};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL cycle_outputs @%0t: got %h expected %h", $time, act_v, exp_v);
      end
      if (arvalid && arready && !rst)
        $display("[TB] AR  id=%0d addr=%h len=%0d", arid, araddr, arlen);
      if (inst_rvalid && inst_rready && !rst) begin
        inst_beats++;
        $display("[TB] R   inst data=%h last=%0b", rdata_out, inst_rlast);
      end
      if (data_rvalid && data_rready && !rst) begin
        data_beats++;
        $display("[TB] R   data data=%h last=%0b", rdata_out, data_rlast);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Address handshake after `stall` cycles of arready low; requester then drops.
  task automatic ar_hs(input bit who, input int stall);
    arready = 1'b0;
    repeat (stall) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    if (who) data_arvalid = 1'b0; else inst_arvalid = 1'b0;
  endtask

  // n back-to-back beats to the given cache, rlast on the final one.
  task automatic beats(input bit who, input int n);
    if (who) data_rready = 1'b1; else inst_rready = 1'b1;
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rdata  = $urandom;
      rlast  = (i == n - 1);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; inst_rready = 1'b0; data_rready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int ib0, db0;

  initial begin
    rst = 1'b1;
    inst_araddr = '0; inst_arlen = '0; inst_arvalid = 1'b0; inst_rready = 1'b0;
    data_araddr = '0; data_arlen = '0; data_arvalid = 1'b0; data_rready = 1'b0;
    arready = 1'b0; rdata = 32'h0; rlast = 1'b0; rvalid = 1'b0;
    tick();
    chk_en = 1'b1;
    // Reset state, with requests present to show they are ignored.
    inst_arvalid = 1'b1; data_arvalid = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678;
    #1;
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_inst_arready", {31'd0, inst_arready}, 32'd0);
    check("rst_rdata_out", rdata_out, 32'h1234_5678);
    tick();
    inst_arvalid = 1'b0; data_arvalid = 1'b0; rvalid = 1'b0;
    rst = 1'b0;
    tick();

    // Single i-cache burst of 8 beats.
    inst_araddr = 32'h1FC0_0000; inst_arlen = 4'd7; inst_arvalid = 1'b1;
    tick();
    check("inst_arvalid_next", {31'd0, arvalid}, 32'd1);
    check("inst_arid", {28'd0, arid}, 32'd0);
    check("inst_araddr", araddr, 32'h1FC0_0000);
    check("inst_arlen", {28'd0, arlen}, 32'd7);
    ar_hs(1'b0, 0);
    beats(1'b0, 8);
    rvalid = 1'b1; #1;
    check("inst_idle_rvalid", {31'd0, inst_rvalid}, 32'd0);
    rvalid = 1'b0;
    check("inst_beats", inst_beats, 32'd8);
    check("inst_no_data_beats", data_beats, 32'd0);
    tick();

    // Simultaneous requests just after reset: data wins, then inst.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    inst_araddr = 32'h0000_4000; inst_arlen = 4'd1; inst_arvalid = 1'b1;
    data_araddr = 32'h8000_0040; data_arlen = 4'd3; data_arvalid = 1'b1;
    tick();
    check("rr_first_arid", {28'd0, arid}, 32'd1);
    check("rr_first_araddr", araddr, 32'h8000_0040);
    ar_hs(1'b1, 0);
    beats(1'b1, 4);
    check("rr_idle_gap_arvalid", {31'd0, arvalid}, 32'd0);
    tick();
    check("rr_second_arid", {28'd0, arid}, 32'd0);
    check("rr_second_arvalid", {31'd0, arvalid}, 32'd1);
    ar_hs(1'b0, 0);
    beats(1'b0, 2);
    tick();

    // d-cache request arriving mid i-cache burst is held off.
    inst_araddr = 32'h0000_1000; inst_arlen = 4'd5; inst_arvalid = 1'b1;
    tick();
    ar_hs(1'b0, 0);
    inst_rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rvalid = 1'b1; rdata = $urandom; rlast = (i == 5);
      if (i == 3) begin
        data_araddr = 32'h0000_2000; data_arlen = 4'd0; data_arvalid = 1'b1;
      end
      #1;
      if (i >= 3) check("holdoff_data_arready", {31'd0, data_arready}, 32'd0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; inst_rready = 1'b0;
    check("holdoff_idle_arvalid", {31'd0, arvalid}, 32'd0);
    tick();
    check("holdoff_grant_arvalid", {31'd0, arvalid}, 32'd1);
    check("holdoff_grant_arid", {28'd0, arid}, 32'd1);
    ar_hs(1'b1, 0);
    beats(1'b1, 1);
    tick();

    // arready stalled five cycles: address must stay put.
    inst_araddr = 32'h0000_3000; inst_arlen = 4'd2; inst_arvalid = 1'b1;
    arready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_arvalid", {31'd0, arvalid}, 32'd1);
      check("stall_araddr", araddr, 32'h0000_3000);
      check("stall_arlen", {28'd0, arlen}, 32'd2);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0; inst_arvalid = 1'b0; inst_rready = 1'b1;
    #1;
    check("stall_data_rready", {31'd0, rready}, 32'd1);
    check("stall_data_arvalid", {31'd0, arvalid}, 32'd0);
    beats(1'b0, 3);
    tick();

    // Single-beat d-cache burst.
    data_araddr = 32'hBFAF_8000; data_arlen = 4'd0; data_arvalid = 1'b1;
    tick();
    check("single_araddr", araddr, 32'hBFAF_8000);
    ar_hs(1'b1, 0);
    data_rready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hCAFE_F00D;
    #1;
    check("single_rlast", {31'd0, data_rlast}, 32'd1);
    check("single_rvalid", {31'd0, data_rvalid}, 32'd1);
    tick();
    check("single_idle_rvalid", {31'd0, data_rvalid}, 32'd0);
    rvalid = 1'b0; rlast = 1'b0; data_rready = 1'b0;
    tick();

    // Address withdrawn in ADDR: nothing issued, back to IDLE.
    inst_araddr = 32'h0000_5000; inst_arlen = 4'd0; inst_arvalid = 1'b1;
    tick();
    inst_arvalid = 1'b0;
    #1;
    check("abort_arvalid", {31'd0, arvalid}, 32'd0);
    tick();
    tick();

    // Reset pulse during beat 4 of a data burst.
    db0 = data_beats;
    data_araddr = 32'h8000_1000; data_arlen = 4'd7; data_arvalid = 1'b1;
    tick();
    ar_hs(1'b1, 0);
    data_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rlast = 1'b0; rdata = $urandom; tick();
    end
    rvalid = 1'b1; rdata = $urandom;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_mid_rready", {31'd0, rready}, 32'd0);
    check("rst_mid_data_rvalid", {31'd0, data_rvalid}, 32'd0);
    tick();
    rvalid = 1'b0; data_rready = 1'b0;
    rst = 1'b0;
    tick();
    check("rst_mid_beats", data_beats - db0, 32'd3);
    ib0 = inst_beats;
    inst_araddr = 32'h0000_6000; inst_arlen = 4'd1; inst_arvalid = 1'b1;
    tick();
    check("post_rst_arvalid", {31'd0, arvalid}, 32'd1);
    check("post_rst_arid", {28'd0, arid}, 32'd0);
    ar_hs(1'b0, 0);
    beats(1'b0, 2);
    check("post_rst_beats", inst_beats - ib0, 32'd2);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_axi_read_arbiter.md
CACHE_AXI_READ_ARBITER -- requirements
Module: cache_axi_read_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all araddr ports.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 inst_araddr  in  ADDR_W  i-cache read burst address.
REQ-005 inst_arlen  in  4  i-cache burst length minus 1.
REQ-006 inst_arvalid  in  1  i-cache read request.
REQ-007 inst_arready  out  1  i-cache address accepted.
REQ-008 inst_rvalid  out  1  beat valid to i-cache.
REQ-009 inst_rlast  out  1  last beat to i-cache.
REQ-010 inst_rready  in  1  i-cache beat accept.
REQ-011 data_araddr  in  ADDR_W  d-cache read burst address.
REQ-012 data_arlen  in  4  d-cache burst length minus 1.
REQ-013 data_arvalid  in  1  d-cache read request.
REQ-014 data_arready  out  1  d-cache address accepted.
REQ-015 data_rvalid  out  1  beat valid to d-cache.
REQ-016 data_rlast  out  1  last beat to d-cache.
REQ-017 data_rready  in  1  d-cache beat accept.
REQ-018 rdata_out  out  32  read beat data shared by both caches.
REQ-019 arid  out  4  AXI ID: 0 = inst, 1 = data.
REQ-020 araddr  out  ADDR_W  AXI read address.
REQ-021 arlen  out  4  AXI burst length.
REQ-022 arvalid  out  1  AXI address valid.
REQ-023 arready  in  1  AXI address ready.
REQ-024 rdata  in  32  AXI read data.
REQ-025 rlast  in  1  AXI last beat.
REQ-026 rvalid  in  1  AXI beat valid.
REQ-027 rready  out  1  AXI beat ready.

Function
REQ-028 FSM states: IDLE, ADDR, DATA; register owner (0 inst, 1 data); register last_owner.
REQ-029 IDLE: one requester valid -> owner = that requester, go ADDR next cycle.
REQ-030 IDLE, both valid -> owner = ~last_owner (round-robin).
REQ-031 ADDR: arvalid = owner's arvalid; araddr/arlen = owner's; arid = {3'b0, owner}; owner's arready = arready; non-owner arready 0.
REQ-032 ADDR: arvalid & arready -> DATA; owner's arvalid low -> IDLE, no AXI address issued.
REQ-033 DATA: owner's rvalid = rvalid, rlast = rlast; rready = owner's rready; non-owner rvalid/rlast 0; rid not checked.
REQ-034 DATA: rvalid & rready & rlast -> IDLE, last_owner <= owner.
REQ-035 IDLE: arvalid, araddr, arlen, arid, rready, both arready, both rvalid/rlast = 0.
REQ-036 rdata_out = rdata combinationally in all states.
REQ-037 Latency: request at cycle N -> arvalid at N+1; one IDLE cycle minimum between bursts.
REQ-038 Burst length from arlen only; a single-beat (arlen 0) burst ends on its first rlast beat.
REQ-039 Request arriving in ADDR/DATA held off (arready 0) until return to IDLE.

Reset
REQ-040 rst asynchronously forces IDLE, owner 0, last_owner 0; all outputs except rdata_out 0 immediately.
REQ-041 rst mid-burst abandons burst; no beats forwarded after rst; first grant after release per REQ-029/030.

Verification
REQ-042 Only inst_arvalid, addr 0x1FC00000, len 7 -> arvalid next cycle, arid 0; 8 beats on inst_rvalid, data_rvalid stays 0; IDLE after rlast.
REQ-043 After reset both request same cycle -> data granted first (arid 1), inst granted after data rlast plus one IDLE cycle.
REQ-044 data_arvalid rises during inst beat 3 -> data_arready 0 until inst rlast; data arvalid issued 2 cycles after inst rlast.
REQ-045 arready low 5 cycles in ADDR -> arvalid, araddr, arlen stable 5 cycles; DATA entered on 6th-cycle handshake.
REQ-046 Data burst, len 0, addr 0xBFAF8000 -> single beat, data_rlast 1, IDLE next cycle.
REQ-047 rst pulse during data beat 4 -> arvalid/rready/data_rvalid 0 same cycle; post-release inst request granted normally.
